// File: rtl/uart_pkg.sv
// uart_pkg: shared state type and default constants for the UART transmit arbiter
package uart_pkg;
  typedef enum logic [1:0] {IDLE, SEND, GAP} arb_state_e;
  localparam int SW_W_DEF = 16;
  localparam int GAP_CYCLES_DEF = 16;
  localparam int BAUD_DIV_100M_115200 = 868;
endpackage

// File: rtl/uart_rr_pick.sv
// uart_rr_pick: combinational round-robin picker, first set request at index >= ptr with wrap
module uart_rr_pick #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic          found_o,
  output logic [IW-1:0] idx_o
);
  logic [IW-1:0] j;
  always_comb begin
    found_o = 1'b0;
    idx_o = '0;
    j = '0;
    // scan from farthest to nearest so the nearest hit is the one that sticks
    for (int k = N - 1; k >= 0; k--) begin
      j = IW'((int'(ptr_i) + k) % N);
      if (req_i[j]) begin
        found_o = 1'b1;
        idx_o = j;
      end
    end
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter among N_REQ byte producers,
// with a programmable idle gap after every completed frame
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int GAP_CYCLES = GAP_CYCLES_DEF,
  parameter int SW_W = SW_W_DEF,
  localparam int IW = $clog2(N_REQ),
  localparam int GW = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]   req_ack,
  input  logic [SW_W-1:0]    cfg_symbol_width,
  output logic               tx_send_req,
  output logic [7:0]         tx_d_in,
  output logic [SW_W-1:0]    tx_symbol_width,
  input  logic               tx_send_ack,
  output logic               busy,
  output logic [IW-1:0]      grant_id
);
  arb_state_e state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d, grant_q, grant_d, pick_idx;
  logic [GW-1:0] gap_q, gap_d;
  logic send_q, send_d, busy_q, busy_d, pick_found;
  logic [7:0] data_q, data_d;
  logic [SW_W-1:0] sw_q, sw_d;
  logic [N_REQ-1:0] ack_q, ack_d;

  uart_rr_pick #(.N(N_REQ)) u_pick (
    .req_i  (req_valid),
    .ptr_i  (ptr_q),
    .found_o(pick_found),
    .idx_o  (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q <= '0;
      grant_q <= '0;
      gap_q <= '0;
      send_q <= 1'b0;
      busy_q <= 1'b0;
      data_q <= '0;
      sw_q <= '0;
      ack_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      grant_q <= grant_d;
      gap_q <= gap_d;
      send_q <= send_d;
      busy_q <= busy_d;
      data_q <= data_d;
      sw_q <= sw_d;
      ack_q <= ack_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    grant_d = grant_q;
    gap_d = gap_q;
    send_d = send_q;
    data_d = data_q;
    sw_d = sw_q;
    ack_d = '0;
    case (state_q)
      IDLE: if (pick_found && cfg_symbol_width != '0) begin
        data_d = req_data[{pick_idx, 3'b000} +: 8];
        sw_d = cfg_symbol_width;
        grant_d = pick_idx;
        send_d = 1'b1;
        state_d = SEND;
      end
      SEND: if (tx_send_ack) begin
        send_d = 1'b0;
        ack_d[grant_q] = 1'b1;
        ptr_d = grant_q == IW'(N_REQ - 1) ? '0 : grant_q + 1'b1;
        gap_d = GW'(GAP_CYCLES - 1);
        state_d = GAP_CYCLES > 0 ? GAP : IDLE;
      end
      GAP: begin
        state_d = gap_q == '0 ? IDLE : GAP;
        gap_d = gap_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
  end

  assign req_ack = ack_q;
  assign tx_send_req = send_q;
  assign tx_d_in = data_q;
  assign tx_symbol_width = sw_q;
  assign busy = busy_q;
  assign grant_id = grant_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: scoreboard bench, expected grants queued at stimulus and checked at each tx_send_req
module tb_uart_tx_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0] req_ack;
  logic [15:0] cfg_symbol_width = 16'd868;
  logic tx_send_req;
  logic [7:0] tx_d_in;
  logic [15:0] tx_symbol_width;
  logic tx_send_ack = 1'b0;
  logic busy;
  logic [1:0] grant_id;

  typedef struct {
    logic [1:0]  id;
    logic [7:0]  d;
    logic [15:0] sw;
  } exp_t;
  exp_t q[$];
  int checks = 0;
  int failures = 0;

  uart_tx_arbiter #(.N_REQ(4), .GAP_CYCLES(16), .SW_W(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ack(req_ack),
    .cfg_symbol_width(cfg_symbol_width), .tx_send_req(tx_send_req), .tx_d_in(tx_d_in),
    .tx_symbol_width(tx_symbol_width), .tx_send_ack(tx_send_ack), .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rst = 1'b1;
    tx_send_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    req_valid = '0;
  endtask

  task automatic push(input logic [1:0] id, input logic [7:0] d, input logic [15:0] sw);
    exp_t e;
    e.id = id;
    e.d = d;
    e.sw = sw;
    q.push_back(e);
  endtask

  // wait for a grant, compare with scoreboard head, hold, ack, then measure the gap
  task automatic run_frame(input int hold, input logic [15:0] mid_cfg, input int spur);
    exp_t e;
    int n;
    int g;
    bit bad;
    n = 0;
    while (tx_send_req !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (tx_send_req !== 1'b1) begin
      failures++;
      $display("FAIL grant_timeout tx_send_req=%b required 1", tx_send_req);
      return;
    end
    checks++;
    if (q.size() == 0) begin
      failures++;
      $display("FAIL unexpected_grant grant_id=%0d with empty scoreboard", grant_id);
      return;
    end
    e = q.pop_front();
    checks++;
    if (grant_id !== e.id) begin
      failures++;
      $display("FAIL grant_id got=%0d exp=%0d", grant_id, e.id);
    end
    checks++;
    if (tx_d_in !== e.d) begin
      failures++;
      $display("FAIL tx_d_in got=%h exp=%h", tx_d_in, e.d);
    end
    checks++;
    if (tx_symbol_width !== e.sw) begin
      failures++;
      $display("FAIL tx_symbol_width got=%0d exp=%0d", tx_symbol_width, e.sw);
    end
    cfg_symbol_width = mid_cfg;
    bad = 0;
    for (int c = 0; c < hold; c++) begin
      @(negedge clk);
      if (tx_send_req !== 1'b1 || tx_d_in !== e.d || tx_symbol_width !== e.sw || req_ack !== 4'b0 || busy !== 1'b1)
        bad = 1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL send_hold outputs changed during SEND got d=%h sw=%0d exp d=%h sw=%0d", tx_d_in, tx_symbol_width, e.d, e.sw);
    end
    tx_send_ack = 1'b1;
    @(negedge clk);
    tx_send_ack = 1'b0;
    checks++;
    if (req_ack !== (4'b0001 << e.id) || tx_send_req !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL ack_pulse req_ack=%b send_req=%b busy=%b exp req_ack=%b send_req=0 busy=1", req_ack, tx_send_req, busy, 4'b0001 << e.id);
    end
    req_valid[e.id] = 1'b0;
    g = (busy === 1'b1) ? 1 : 0;
    bad = 0;
    for (int c = 0; c < 40 && busy === 1'b1; c++) begin
      tx_send_ack = (c == spur);
      @(negedge clk);
      if (req_ack !== 4'b0 || tx_send_req !== 1'b0) bad = 1;
      if (busy === 1'b1) g++;
    end
    tx_send_ack = 1'b0;
    checks++;
    if (g != 16 || bad) begin
      failures++;
      $display("FAIL gap_length busy_cycles=%0d exp=16 stray_output=%0d", g, bad);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 4'b1111;
    req_data = 32'hDDCCBBAA;
    tx_send_ack = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (tx_send_req !== 1'b0 || tx_d_in !== 8'h00 || tx_symbol_width !== 16'd0 || req_ack !== 4'b0 || busy !== 1'b0 || grant_id !== 2'd0) begin
      failures++;
      $display("FAIL reset_state send=%b d=%h sw=%0d ack=%b busy=%b gid=%0d exp all zero", tx_send_req, tx_d_in, tx_symbol_width, req_ack, busy, grant_id);
    end
    tx_send_ack = 1'b0;
    rst = 1'b0;
    req_valid = '0;
    @(negedge clk);
  endtask

  task automatic test_single();
    do_reset();
    cfg_symbol_width = 16'd868;
    req_data = 32'h00A50000;
    req_valid = 4'b0100;
    @(negedge clk);
    checks++;
    if (tx_send_req !== 1'b1 || tx_d_in !== 8'hA5 || tx_symbol_width !== 16'd868 || grant_id !== 2'd2 || busy !== 1'b1) begin
      failures++;
      $display("FAIL single_latency send=%b d=%h sw=%0d gid=%0d busy=%b exp 1 a5 868 2 1", tx_send_req, tx_d_in, tx_symbol_width, grant_id, busy);
    end
    push(2'd2, 8'hA5, 16'd868);
    run_frame(4, 16'd868, -1);
  endtask

  task automatic test_round_robin();
    do_reset();
    req_data = 32'h43322110;
    req_valid = 4'b1111;
    push(2'd0, 8'h10, 16'd868);
    push(2'd1, 8'h21, 16'd868);
    push(2'd2, 8'h32, 16'd868);
    push(2'd3, 8'h43, 16'd868);
    push(2'd0, 8'h50, 16'd868);
    run_frame(3, 16'd868, -1);
    req_data[7:0] = 8'h50;
    req_valid[0] = 1'b1;
    for (int f = 0; f < 4; f++) run_frame(2, 16'd868, -1);
  endtask

  task automatic test_wrap();
    do_reset();
    req_data = 32'hC3001100 | 32'h000000C0;
    req_valid = 4'b0010;
    push(2'd1, 8'h11, 16'd868);
    run_frame(2, 16'd868, -1);
    req_valid = 4'b1001;
    push(2'd3, 8'hC3, 16'd868);
    push(2'd0, 8'hC0, 16'd868);
    run_frame(2, 16'd868, -1);
    run_frame(2, 16'd868, -1);
  endtask

  task automatic test_cfg();
    int bad;
    do_reset();
    cfg_symbol_width = 16'd868;
    req_data = 32'h00004D3C;
    req_valid = 4'b0001;
    push(2'd0, 8'h3C, 16'd868);
    run_frame(5, 16'd434, -1);
    req_valid = 4'b0010;
    push(2'd1, 8'h4D, 16'd434);
    run_frame(2, 16'd434, -1);
    cfg_symbol_width = 16'd0;
    req_data[23:16] = 8'h66;
    req_valid = 4'b0100;
    bad = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (tx_send_req !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL cfg_zero_grant tx_send_req high for %0d cycles exp 0", bad);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL cfg_zero_busy busy=%b exp 0", busy);
    end
    cfg_symbol_width = 16'd868;
    push(2'd2, 8'h66, 16'd868);
    run_frame(1, 16'd868, -1);
  endtask

  task automatic test_reset_mid();
    int n;
    do_reset();
    req_data = 32'hA3A2A1A0;
    req_valid = 4'b0010;
    push(2'd1, 8'hA1, 16'd868);
    run_frame(2, 16'd868, -1);
    req_valid = 4'b1101;
    n = 0;
    while (tx_send_req !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (tx_send_req !== 1'b1 || grant_id !== 2'd2) begin
      failures++;
      $display("FAIL pre_reset_grant send=%b gid=%0d exp 1 and 2", tx_send_req, grant_id);
    end
    @(negedge clk);
    rst = 1'b1;
    tx_send_ack = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tx_send_ack = 1'b0;
    checks++;
    if (tx_send_req !== 1'b0 || req_ack !== 4'b0 || busy !== 1'b0 || grant_id !== 2'd0) begin
      failures++;
      $display("FAIL reset_mid send=%b ack=%b busy=%b gid=%0d exp 0 0000 0 0", tx_send_req, req_ack, busy, grant_id);
    end
    push(2'd0, 8'hA0, 16'd868);
    run_frame(2, 16'd868, -1);
    req_valid = '0;
  endtask

  task automatic test_spurious();
    do_reset();
    @(negedge clk);
    tx_send_ack = 1'b1;
    @(negedge clk);
    tx_send_ack = 1'b0;
    checks++;
    if (req_ack !== 4'b0 || busy !== 1'b0 || tx_send_req !== 1'b0) begin
      failures++;
      $display("FAIL idle_spurious_ack ack=%b busy=%b send=%b exp 0000 0 0", req_ack, busy, tx_send_req);
    end
    req_data = 32'h77000000;
    req_valid = 4'b1000;
    push(2'd3, 8'h77, 16'd868);
    run_frame(2, 16'd868, 5);
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_cfg();
    test_reset_mid();
    test_spurious();
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain left=%0d exp 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
